pipeline_deser_stage: RTL and testbench
=======================================

Name: pipeline_deser_stage

Overview:
- Downstream consumer of the 1-bit pipeline latch stage.
- Accepts serial bits over the previous/next handshake: previous = upstream valid, next = this stage ready.
- Packs WIDTH bits into a word and presents it on a registered valid/ready output port.
- Decouples the bit-rate pipeline from word-wide logic, with full backpressure and one pending word of buffering.

Parameters:
- WIDTH, 8, bits per assembled word (minimum 2).
- MSB_FIRST, 0: 0 = first accepted bit lands in word bit 0; 1 = first accepted bit lands in word bit WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-low.
- data_in  input  1  serial bit from the upstream latch's data_out.
- previous  input  1  upstream valid; data_in is meaningful while high.
- next  output  1  ready to upstream; a bit transfers on an edge where previous && next.
- word_out  output  WIDTH  assembled word, registered.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  downstream ready; a word transfers on an edge where word_valid && word_ready.
- bit_count  output  clog2(WIDTH)  number of bits collected in the current partial word.
- pending  output  1  a complete word is waiting in the shift register for the output slot.

Behaviour:
- Reset (RST low, asynchronous):
  - shift register = 0, bit_count = 0, pending = 0.
  - word_out = 0, word_valid = 0.
  - Takes effect immediately, including mid-word; the partial word is discarded.
  - Release is synchronous to clk.
- slot_free = !word_valid || word_ready. This is combinational.
- next = !pending || slot_free.
  - next is combinational from word_ready; there is no path from previous to next.
- Bit accept (previous && next):
  - The bit is shifted into position bit_count (LSB-first) or WIDTH-1-bit_count (MSB-first).
  - bit_count increments.
  - On accepting the bit where bit_count == WIDTH-1: bit_count wraps to 0 and the word completes.
- Word completion with the slot free: word_out loads the completed word and word_valid = 1 on that same edge. Latency from last bit accepted to word_valid is 1 cycle.
- Word completion with the slot not free: the word is held in the shift register and pending = 1.
  - next stays low until slot_free.
- Pending with slot_free at an edge:
  - word_out is loaded from the held word and pending clears.
  - The same edge may also accept a new bit into position 0 of a fresh word (bit_count becomes 1).
  - The held word is captured before the shift register clears.
- Output handshake: word_valid stays high and word_out stays stable until an edge with word_ready.
  - If a new word transfers on that same edge, word_valid stays 1 and word_out updates (back-to-back words, no bubble).
  - Otherwise word_valid drops to 0.
- Throughput: with word_ready held high, one bit is accepted per cycle indefinitely and one word is produced every WIDTH cycles.
- Gaps: previous low leaves all state unchanged. data_in is ignored when the transfer does not occur.
- No overflow is possible. Storage is at most one word in word_out plus one pending word. Backpressure is lossless.

Decomposition:
- Shared package pipeline_pkg holds:
  - the handshake transfer-condition helper (valid && ready);
  - a default word width constant PIPE_WORD_W = 8;
  - the bit-order encodings ORDER_LSB = 0 and ORDER_MSB = 1.
- One sub-module, pipeline_bit_collector: shift register plus bit_count and the completion pulse.
- The top level adds the pending flag, output register and ready logic.

Test Plan:
- Reset mid-word: after 3 bits 1,0,1 are accepted, pulse RST low for 2 ns asynchronously (no clk edge) -> bit_count = 0, word_valid = 0, word_out = 0 immediately. The next 8 bits form a fresh word.
- Streaming, LSB-first, WIDTH = 8, word_ready = 1, previous = 1, bits 1,0,1,1,0,0,1,0 -> word_out = 8'h4D, word_valid high 1 cycle after the 8th bit, next never drops.
- MSB_FIRST = 1, same bit sequence -> word_out = 8'hB2.
- Backpressure with word_ready = 0:
  - Send 16 bits (8'hFF then 8'h0F) -> first word sits in word_out, second sets pending = 1, next = 0, a 17th bit is not accepted.
  - Raise word_ready for 1 cycle -> word_out = 8'h0F, pending = 0, next = 1.
- Simultaneous events: word_ready = 1 on the same edge the 8th bit of the next word is accepted -> word_valid stays 1 and word_out changes to the new word with no idle cycle. The monitor sees exactly one transfer per word.
- Gapped upstream: previous toggles 1,0,1,0 across 16 cycles carrying 8 bits -> bit_count holds during gaps and the correct word is produced after the 8th accepted bit.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared handshake helpers and constants for the bit-serial pipeline stages.
package pipeline_pkg;

  localparam int PIPE_WORD_W = 8;
  localparam bit ORDER_LSB   = 1'b0;
  localparam bit ORDER_MSB   = 1'b1;

  function automatic logic xfer(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage

// File: rtl/pipeline_bit_collector.sv
// Shift register and bit counter that pack accepted serial bits into a word.
import pipeline_pkg::*;

module pipeline_bit_collector #(
  parameter int WIDTH     = PIPE_WORD_W,
  parameter bit MSB_FIRST = ORDER_LSB,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             accept_i,
  input  logic             bit_i,
  input  logic             keep_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] word_o,
  output logic [WIDTH-1:0] held_o,
  output logic [CW-1:0]    count_o,
  output logic             done_o
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] base_s;
  logic [WIDTH-1:0] word_s;
  logic [CW-1:0]    pos_s;
  logic             last_s;

  // Insert the incoming bit; a cleared held word starts the fresh word from zero.
  always_comb begin
    if (clear_i) begin
      base_s = '0;
    end else begin
      base_s = shift_q;
    end
    if (MSB_FIRST == ORDER_MSB) begin
      pos_s = CW'(WIDTH - 1) - count_q;
    end else begin
      pos_s = count_q;
    end
    word_s        = base_s;
    word_s[pos_s] = bit_i;
    last_s        = (count_q == CW'(WIDTH - 1));
    shift_d       = base_s;
    count_d       = count_q;
    if (accept_i) begin
      if (last_s) begin
        count_d = '0;
        if (keep_i) begin
          shift_d = word_s;
        end else begin
          shift_d = '0;
        end
      end else begin
        count_d = count_q + CW'(1);
        shift_d = word_s;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Collector state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  assign word_o  = word_s;
  assign held_o  = shift_q;
  assign count_o = count_q;
  assign done_o  = accept_i && last_s;

endmodule

// File: rtl/pipeline_deser_stage.sv
// Serial-to-parallel stage: collects WIDTH bits and offers them on a registered valid/ready port.
import pipeline_pkg::*;

module pipeline_deser_stage #(
  parameter int WIDTH     = PIPE_WORD_W,
  parameter bit MSB_FIRST = ORDER_LSB
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     data_in,
  input  logic                     previous,
  output logic                     next,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     pending
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             pending_q, pending_d;
  logic             slot_free_s;
  logic             accept_s;
  logic             release_s;
  logic             done_s;
  logic [WIDTH-1:0] done_word_s;
  logic [WIDTH-1:0] held_word_s;

  assign slot_free_s = !valid_q || word_ready;
  assign next        = !pending_q || slot_free_s;
  assign accept_s    = xfer(previous, next);
  assign release_s   = pending_q && slot_free_s;

  pipeline_bit_collector #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_collector (
    .clk_i   (clk),
    .rst_ni  (RST),
    .accept_i(accept_s),
    .bit_i   (data_in),
    .keep_i  (!slot_free_s),
    .clear_i (release_s),
    .word_o  (done_word_s),
    .held_o  (held_word_s),
    .count_o (bit_count),
    .done_o  (done_s)
  );

  // Output slot: a held word always drains before a newly completed one can complete.
  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    if (release_s) begin
      word_d    = held_word_s;
      valid_d   = 1'b1;
      pending_d = 1'b0;
    end else if (done_s && slot_free_s) begin
      word_d  = done_word_s;
      valid_d = 1'b1;
    end else if (done_s) begin
      pending_d = 1'b1;
    end else if (xfer(valid_q, word_ready)) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output and pending registers.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_pipeline_deser_stage.sv
// Directed bench for pipeline_deser_stage: LSB-first and MSB-first instances share one stimulus.
module tb_pipeline_deser_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b0;
  logic       previous = 1'b0;
  logic       word_ready = 1'b0;

  logic       lsb_next, lsb_valid, lsb_pending;
  logic [7:0] lsb_word;
  logic [2:0] lsb_count;
  logic       msb_next, msb_valid, msb_pending;
  logic [7:0] msb_word;
  logic [2:0] msb_count;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;

  always #5 clk = ~clk;

  pipeline_deser_stage #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .RST(rst_n), .data_in(data_in), .previous(previous), .next(lsb_next),
    .word_out(lsb_word), .word_valid(lsb_valid), .word_ready(word_ready),
    .bit_count(lsb_count), .pending(lsb_pending)
  );

  pipeline_deser_stage #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .RST(rst_n), .data_in(data_in), .previous(previous), .next(msb_next),
    .word_out(msb_word), .word_valid(msb_valid), .word_ready(word_ready),
    .bit_count(msb_count), .pending(msb_pending)
  );

  always @(posedge clk) begin
    if (lsb_valid && word_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    previous = 1'b1;
    data_in  = b;
    step();
    previous = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic pulse_reset();
    previous = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", lsb_valid); end
    checks++; if (lsb_word !== 8'h00) begin errors++; $display("FAIL rst_word got %h exp 00", lsb_word); end
    checks++; if (lsb_count !== 3'd0 || lsb_pending !== 1'b0) begin errors++; $display("FAIL rst_count_pending got %0d/%b exp 0/0", lsb_count, lsb_pending); end
    checks++; if (lsb_next !== 1'b1) begin errors++; $display("FAIL rst_next got %b exp 1", lsb_next); end
    #9 rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_word();
    word_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checks++; if (lsb_count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d exp 3", lsb_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (lsb_count !== 3'd0 || msb_count !== 3'd0) begin errors++; $display("FAIL async_count got %0d/%0d exp 0/0", lsb_count, msb_count); end
    checks++; if (lsb_valid !== 1'b0 || lsb_word !== 8'h00) begin errors++; $display("FAIL async_out got %b/%h exp 0/00", lsb_valid, lsb_word); end
    #1 rst_n = 1'b1;
    send_word(8'h3A);
    checks++; if (lsb_valid !== 1'b1 || lsb_word !== 8'h3A) begin errors++; $display("FAIL fresh_lsb got %b/%h exp 1/3a", lsb_valid, lsb_word); end
    checks++; if (msb_word !== 8'h5C) begin errors++; $display("FAIL fresh_msb got %h exp 5c", msb_word); end
  endtask

  task automatic test_streaming();
    logic [7:0] w;
    int         next_drops;
    w = 8'h4D;
    next_drops = 0;
    word_ready = 1'b1;
    previous = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = w[i];
      #1;
      if (lsb_next !== 1'b1) next_drops++;
      step();
      previous = 1'b1;
      if (i == 6) begin
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %b exp 0", lsb_valid); end
      end
    end
    checks++; if (next_drops !== 0) begin errors++; $display("FAIL stream_next_drops got %0d exp 0", next_drops); end
    checks++; if (lsb_valid !== 1'b1 || lsb_word !== 8'h4D) begin errors++; $display("FAIL stream_lsb got %b/%h exp 1/4d", lsb_valid, lsb_word); end
    checks++; if (msb_valid !== 1'b1 || msb_word !== 8'hB2) begin errors++; $display("FAIL stream_msb got %b/%h exp 1/b2", msb_valid, msb_word); end
    checks++; if (lsb_count !== 3'd0) begin errors++; $display("FAIL stream_wrap got %0d exp 0", lsb_count); end
    w = 8'h01;
    for (int i = 0; i < 8; i++) begin
      data_in = w[i];
      step();
      previous = 1'b1;
      if (i == 0) begin
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL stream_drop got %b exp 0", lsb_valid); end
      end
    end
    previous = 1'b0;
    checks++; if (lsb_word !== 8'h01 || msb_word !== 8'h80) begin errors++; $display("FAIL stream_w2 got %h/%h exp 01/80", lsb_word, msb_word); end
  endtask

  task automatic test_backpressure();
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", lsb_valid); end
    send_word(8'hFF);
    checks++; if (lsb_valid !== 1'b1 || lsb_word !== 8'hFF || lsb_pending !== 1'b0) begin errors++; $display("FAIL bp_first got %b/%h/%b exp 1/ff/0", lsb_valid, lsb_word, lsb_pending); end
    send_word(8'h0F);
    checks++; if (lsb_pending !== 1'b1 || lsb_next !== 1'b0) begin errors++; $display("FAIL bp_pending got %b/%b exp 1/0", lsb_pending, lsb_next); end
    checks++; if (lsb_word !== 8'hFF) begin errors++; $display("FAIL bp_hold got %h exp ff", lsb_word); end
    send_bit(1'b1);
    checks++; if (lsb_count !== 3'd0 || lsb_pending !== 1'b1) begin errors++; $display("FAIL bp_reject got %0d/%b exp 0/1", lsb_count, lsb_pending); end
    previous = 1'b1;
    data_in = 1'b1;
    word_ready = 1'b1;
    #1;
    checks++; if (lsb_next !== 1'b1) begin errors++; $display("FAIL bp_next_comb got %b exp 1", lsb_next); end
    step();
    previous = 1'b0;
    word_ready = 1'b0;
    #1;
    checks++; if (lsb_word !== 8'h0F || lsb_valid !== 1'b1 || lsb_pending !== 1'b0) begin errors++; $display("FAIL bp_release got %h/%b/%b exp 0f/1/0", lsb_word, lsb_valid, lsb_pending); end
    checks++; if (msb_word !== 8'hF0) begin errors++; $display("FAIL bp_release_msb got %h exp f0", msb_word); end
    checks++; if (lsb_count !== 3'd1 || lsb_next !== 1'b1) begin errors++; $display("FAIL bp_same_edge got %0d/%b exp 1/1", lsb_count, lsb_next); end
    pulse_reset();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'h96;
    word_ready = 1'b0;
    send_word(8'h4D);
    checks++; if (lsb_valid !== 1'b1 || lsb_word !== 8'h4D) begin errors++; $display("FAIL b2b_first got %b/%h exp 1/4d", lsb_valid, lsb_word); end
    xfer_cnt = 0;
    for (int i = 0; i < 7; i++) send_bit(w[i]);
    checks++; if (lsb_word !== 8'h4D || lsb_pending !== 1'b0 || lsb_count !== 3'd7) begin errors++; $display("FAIL b2b_wait got %h/%b/%0d exp 4d/0/7", lsb_word, lsb_pending, lsb_count); end
    word_ready = 1'b1;
    send_bit(w[7]);
    checks++; if (lsb_valid !== 1'b1 || lsb_word !== 8'h96 || lsb_pending !== 1'b0) begin errors++; $display("FAIL b2b_swap got %b/%h/%b exp 1/96/0", lsb_valid, lsb_word, lsb_pending); end
    checks++; if (xfer_cnt !== 1) begin errors++; $display("FAIL b2b_xfer1 got %0d exp 1", xfer_cnt); end
    step();
    word_ready = 1'b0;
    checks++; if (lsb_valid !== 1'b0 || xfer_cnt !== 2) begin errors++; $display("FAIL b2b_drain got %b/%0d exp 0/2", lsb_valid, xfer_cnt); end
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    int         bad_hold;
    w = 8'h5A;
    bad_hold = 0;
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i]);
      if (i == 7) begin
        checks++; if (lsb_valid !== 1'b1 || lsb_word !== 8'h5A) begin errors++; $display("FAIL gap_word got %b/%h exp 1/5a", lsb_valid, lsb_word); end
      end
      previous = 1'b0;
      data_in = ~w[i];
      step();
      if (lsb_count !== 3'((i + 1) % 8)) bad_hold++;
    end
    checks++; if (bad_hold !== 0) begin errors++; $display("FAIL gap_hold got %0d exp 0", bad_hold); end
    checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL gap_drain got %b exp 1'b0", lsb_valid); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_word();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_gapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
